// File: rtl/prog_encoder.sv
// Instruction-word encoder: packs request fields into 32-bit words, buffers them
// in a 4-deep FIFO and writes them to consecutive instruction-memory addresses.
module prog_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_last,
  input  logic [3:0]  in_cond,
  input  logic [1:0]  in_op,
  input  logic [5:0]  in_funct,
  input  logic [3:0]  in_rn,
  input  logic [3:0]  in_rd,
  input  logic [11:0] in_src2,
  input  logic [23:0] in_off24,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  input  logic        wr_ack,
  output logic        done,
  output logic        err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]  state, state_next;
  logic [31:0] mem [4];
  logic [1:0]  wr_ptr, rd_ptr;
  logic [2:0]  count, count_next;
  logic [31:0] addr;
  logic        err_q;
  logic [31:0] enc_word;
  logic        hs, reserved, push, pop, start_ok;

  assign in_ready = (state == S_RUN) && (count < 3'd4);
  assign hs       = in_valid && in_ready;
  assign reserved = (in_op == 2'b11);
  assign push     = hs && !reserved;
  assign wr_en    = (count != 3'd0);
  assign pop      = wr_en && wr_ack;
  assign start_ok = start && ((state == S_IDLE) || (state == S_DONE));

  assign count_next = count + {2'b00, push} - {2'b00, pop};

  assign wr_addr = addr;
  assign wr_data = wr_en ? mem[rd_ptr] : 32'h0;
  assign done    = (state == S_DONE);
  assign err     = err_q;

  // Branches carry only funct[5:4]; the low 24 bits hold the word offset.
  always_comb begin
    if (in_op == 2'b10)
      enc_word = {in_cond, 2'b10, in_funct[5:4], in_off24};
    else
      enc_word = {in_cond, in_op, in_funct, in_rn, in_rd, in_src2};
  end

  // Enter DONE as soon as the final request has left nothing to write, so a
  // reserved last request on an empty FIFO finishes on the following cycle.
  always_comb begin
    // NOTE: default assignment first so every path assigns state_next and no latch is inferred.
    state_next = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_next = S_RUN;
      S_RUN:          if (hs && in_last)
                        state_next = (count_next == 3'd0) ? S_DONE : S_DRAIN;
      S_DRAIN:        if (count_next == 3'd0) state_next = S_DONE;
      default:        state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!reset) begin
      state  <= S_IDLE;
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
      addr   <= 32'h0;
      err_q  <= 1'b0;
    end else begin
      state <= state_next;
      count <= count_next;
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      if (start_ok)
        addr <= base_addr;
      else if (pop)
        addr <= addr + 32'd4;
      if (start_ok)
        err_q <= 1'b0;
      else if (hs && reserved)
        err_q <= 1'b1;
    end
  end

  // NOTE: storage is not reset; wr_data is gated by wr_en so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= enc_word;
  end

endmodule

// File: tb/tb_prog_encoder.sv
// Self-checking bench for prog_encoder: directed scenarios plus randomized sessions
// compared against a queue-based reference model of the expected memory writes.
module tb_prog_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] base_addr;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [3:0]  in_cond;
  logic [1:0]  in_op;
  logic [5:0]  in_funct;
  logic [3:0]  in_rn;
  logic [3:0]  in_rd;
  logic [11:0] in_src2;
  logic [23:0] in_off24;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_ack;
  logic        done;
  logic        err;

  typedef struct packed {
    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [11:0] src2;
    logic [23:0] off24;
  } req_t;

  int n_cmp = 0;
  int n_bad = 0;
  int ack_pct = 100;

  // Reference model state: each queue entry is {address, word} of a pending write.
  logic [63:0] q[$];
  logic [31:0] m_addr = 32'h0;
  bit          m_err = 1'b0;
  bit          running = 1'b0;
  bit          last_seen = 1'b0;
  int          wr_cnt = 0;
  int          hs_cnt = 0;
  logic [31:0] last_wr_addr = 32'h0;
  logic [31:0] last_wr_data = 32'h0;
  logic [31:0] first_wr_addr = 32'h0;

  prog_encoder dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_cond(in_cond), .in_op(in_op), .in_funct(in_funct),
    .in_rn(in_rn), .in_rd(in_rd), .in_src2(in_src2), .in_off24(in_off24),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] encode(input req_t r);
    logic [31:0] w;
    w = 32'(r.cond) << 28;
    if (r.op == 2'd2)
      w = w + (32'd2 << 26) + ((32'(r.funct) >> 4) << 24) + 32'(r.off24);
    else
      w = w + (32'(r.op) << 26) + (32'(r.funct) << 20) + (32'(r.rn) << 16)
            + (32'(r.rd) << 12) + 32'(r.src2);
    return w;
  endfunction

  function automatic req_t rand_req(input int reserved_pct);
    req_t r;
    r = req_t'({$urandom, $urandom, $urandom});
    if ($urandom_range(1, 100) <= reserved_pct) r.op = 2'b11;
    else r.op = 2'($urandom_range(0, 2));
    return r;
  endfunction

  // Memory side: random acknowledge pattern.
  initial begin
    wr_ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      wr_ack = ($urandom_range(1, 100) <= ack_pct);
    end
  end

  // Monitor: outputs are sampled mid-cycle, when all inputs for the next edge are settled.
  always @(negedge clk) begin
    bit open;
    if (!reset) begin
      q.delete();
      running = 1'b0;
      last_seen = 1'b0;
      m_err = 1'b0;
    end else begin
      open = running || (last_seen && q.size() != 0);
      check("in_ready", {31'b0, in_ready}, {31'b0, running && q.size() < 4});
      check("wr_en", {31'b0, wr_en}, {31'b0, q.size() != 0});
      check("done", {31'b0, done}, {31'b0, last_seen && q.size() == 0});
      check("err", {31'b0, err}, {31'b0, m_err});
      if (wr_en && q.size() != 0) begin
        check("wr_addr", wr_addr, q[0][63:32]);
        check("wr_data", wr_data, q[0][31:0]);
        if (wr_ack) begin
          if (wr_cnt == 0) first_wr_addr = wr_addr;
          last_wr_addr = wr_addr;
          last_wr_data = wr_data;
          wr_cnt++;
          void'(q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        req_t r;
        r = '{in_cond, in_op, in_funct, in_rn, in_rd, in_src2, in_off24};
        hs_cnt++;
        if (in_op == 2'b11) m_err = 1'b1;
        else begin
          q.push_back({m_addr, encode(r)});
          m_addr = m_addr + 32'd4;
        end
        if (in_last) begin
          running = 1'b0;
          last_seen = 1'b1;
        end
      end
      if (start && !open) begin
        m_addr = base_addr;
        m_err = 1'b0;
        running = 1'b1;
        last_seen = 1'b0;
      end
    end
  end

  task automatic cycle();
    @(posedge clk); #1;
  endtask

  task automatic start_session(input logic [31:0] base);
    wr_cnt = 0;
    hs_cnt = 0;
    start = 1'b1;
    base_addr = base;
    cycle();
    start = 1'b0;
  endtask

  task automatic send(input req_t r, input bit last);
    bit acc;
    {in_cond, in_op, in_funct, in_rn, in_rd, in_src2, in_off24} = r;
    in_last = last;
    in_valid = 1'b1;
    for (int w = 0; w < 300; w++) begin
      @(negedge clk);
      acc = in_ready;
      cycle();
      if (acc) begin
        in_valid = 1'b0;
        in_last = 1'b0;
        return;
      end
    end
    check("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (done) break;
    end
    check("done_timeout", {31'b0, done}, 32'd1);
    cycle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    req_t r;
    reset = 1'b0; start = 1'b0; base_addr = '0; in_valid = 1'b0; in_last = 1'b0;
    {in_cond, in_op, in_funct, in_rn, in_rd, in_src2, in_off24} = '0;
    repeat (3) cycle();
    @(negedge clk);
    check("rst_wr_en", {31'b0, wr_en}, 32'd0);
    check("rst_wr_addr", wr_addr, 32'h0);
    check("rst_wr_data", wr_data, 32'h0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    cycle();
    reset = 1'b1;
    repeat (2) cycle();

    // Single data-processing word with immediate acknowledge.
    ack_pct = 100;
    start_session(32'h100);
    send('{4'hE, 2'b00, 6'h28, 4'h1, 4'h2, 12'h005, 24'h0}, 1'b1);
    wait_done();
    check("dp_word", last_wr_data, 32'hE2812005);
    check("dp_addr", last_wr_addr, 32'h100);
    check("dp_count", wr_cnt, 1);

    // Branch encoding.
    start_session(32'h40);
    send('{4'hE, 2'b10, 6'h20, 4'h0, 4'h0, 12'h0, 24'hFFFFFE}, 1'b1);
    wait_done();
    check("br_word", last_wr_data, 32'hEAFFFFFE);

    // Back-pressure: six requests with the memory stalled.
    ack_pct = 0;
    start_session(32'h1000);
    fork
      for (int i = 0; i < 6; i++) send(rand_req(0), i == 5);
      begin
        repeat (12) @(negedge clk);
        check("stall_accepted", hs_cnt, 4);
        check("stall_ready", {31'b0, in_ready}, 32'd0);
        ack_pct = 100;
      end
    join
    wait_done();
    check("bp_count", wr_cnt, 6);
    check("bp_first", first_wr_addr, 32'h1000);
    check("bp_last", last_wr_addr, 32'h1014);

    // Address wrap at the top of the address space.
    ack_pct = 60;
    start_session(32'hFFFF_FFF8);
    for (int i = 0; i < 3; i++) send(rand_req(0), i == 2);
    wait_done();
    check("wrap_first", first_wr_addr, 32'hFFFF_FFF8);
    check("wrap_last", last_wr_addr, 32'h0);

    // Reserved op in the middle of a session.
    ack_pct = 50;
    start_session(32'h500);
    send(rand_req(0), 1'b0);
    r = rand_req(100);
    send(r, 1'b0);
    send(rand_req(0), 1'b1);
    wait_done();
    check("rsv_count", wr_cnt, 2);
    check("rsv_err", {31'b0, err}, 32'd1);

    // Reserved last request on an empty FIFO finishes the next cycle; err clears on start.
    start_session(32'h600);
    @(negedge clk);
    check("restart_err", {31'b0, err}, 32'd0);
    cycle();
    send(rand_req(100), 1'b1);
    @(negedge clk);
    check("rsv_last_done", {31'b0, done}, 32'd1);
    check("rsv_last_err", {31'b0, err}, 32'd1);
    cycle();

    // Reset with two words queued, then restart from a new base.
    ack_pct = 0;
    start_session(32'h200);
    send(rand_req(0), 1'b0);
    send(rand_req(0), 1'b0);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    check("arst_wr_en", {31'b0, wr_en}, 32'd0);
    check("arst_wr_addr", wr_addr, 32'h0);
    check("arst_wr_data", wr_data, 32'h0);
    check("arst_in_ready", {31'b0, in_ready}, 32'd0);
    repeat (2) cycle();
    reset = 1'b1;
    ack_pct = 100;
    repeat (3) cycle();
    @(negedge clk);
    check("post_rst_idle", {31'b0, wr_en}, 32'd0);
    cycle();
    start_session(32'h300);
    send(rand_req(0), 1'b1);
    wait_done();
    check("post_rst_addr", first_wr_addr, 32'h300);

    // Randomized sessions.
    for (int s = 0; s < 20; s++) begin
      int n;
      n = $urandom_range(1, 8);
      ack_pct = $urandom_range(20, 100);
      start_session($urandom & 32'hFFFF_FFFC);
      for (int i = 0; i < n; i++) begin
        send(rand_req(10), i == n - 1);
        repeat ($urandom_range(0, 2)) cycle();
      end
      wait_done();
      check("rand_drained", q.size(), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
